// File: rtl/qm_mq.sv
// Multi-queue output port manager: filters fabric frames by port map, stores payloads in NQ
// strict-priority queues, and serves a head-of-line pointer plus byte read port. Option: QM_STATS_EN.
module qm_mq #(
  parameter int unsigned NQ      = 2,
  parameter int unsigned DAW     = 12,
  parameter int unsigned PAW     = 5,
  parameter int unsigned MAX_FRM = 1518,
  localparam int unsigned QW     = (NQ > 1) ? $clog2(NQ) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    port_id,
  input  logic          sof,
  input  logic          dv,
  input  logic [QW-1:0] prio,
  input  logic [7:0]    data,
  output logic          bp,
  output logic          ptr_valid,
  output logic [QW-1:0] ptr_q,
  output logic [11:0]   ptr_len,
  input  logic          ptr_rd,
  input  logic          data_rd,
  output logic [7:0]    data_dout,
  output logic          rd_busy
`ifdef QM_STATS_EN
  ,
  output logic [31:0]   stat_frm,
  output logic [31:0]   stat_drop
`endif
);

  localparam int unsigned Depth  = 2 ** DAW;
  localparam int unsigned PDepth = 2 ** PAW;
  localparam logic [DAW:0] DepthW   = (DAW + 1)'(Depth);
  localparam logic [DAW:0] BpThresh = (DAW + 1)'(Depth - MAX_FRM);
  localparam logic [PAW:0] PFull    = (PAW + 1)'(PDepth);

  typedef enum logic [2:0] {StIdle, StHdr1, StData, StCommit, StDrop} wst_e;

  wst_e          st_q;
  logic [QW-1:0] wq_q;
  logic [3:0]    len_hi_q;
  logic [11:0]   pay_q;
  logic [11:0]   wcnt_q;

  logic [7:0]  dmem [NQ][Depth];
  logic [11:0] pmem [NQ][PDepth];

  logic [DAW-1:0] tail_q [NQ];
  logic [DAW-1:0] tail_d [NQ];
  logic [DAW-1:0] head_q [NQ];
  logic [DAW-1:0] head_d [NQ];
  logic [DAW:0]   used_q [NQ];
  logic [DAW:0]   used_d [NQ];
  logic [PAW-1:0] pw_q   [NQ];
  logic [PAW-1:0] pw_d   [NQ];
  logic [PAW-1:0] pr_q   [NQ];
  logic [PAW-1:0] pr_d   [NQ];
  logic [PAW:0]   pcnt_q [NQ];
  logic [PAW:0]   pcnt_d [NQ];

  logic [QW-1:0] rq_q;
  logic [11:0]   rem_q;
  logic          rd_busy_d;

  logic [11:0]   hdr_len;
  logic [11:0]   hdr_pay;
  logic [DAW:0]  hdr_free;
  logic          hdr_drop;
  logic          wr_en;
  logic          commit;
  logic          pop;
  logic          rd_en;
  logic          sel_v;
  logic [QW-1:0] sel;
  logic [11:0]   sel_len;
  logic          bp_d;

  assign hdr_len  = {len_hi_q, data};
  assign hdr_pay  = hdr_len - 12'd2;
  assign hdr_free = DepthW - used_q[wq_q];
  assign hdr_drop = (hdr_len <= 12'd2) || (32'(hdr_pay) > 32'(hdr_free)) ||
                    (pcnt_q[wq_q] == PFull);

  assign wr_en  = (st_q == StData) && dv && (wcnt_q < pay_q);
  assign commit = (st_q == StCommit) && (wcnt_q != 12'd0);
  assign pop    = ptr_rd && ptr_valid && !rd_busy;
  assign rd_en  = data_rd && rd_busy;

  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      tail_d[i] = tail_q[i];
      head_d[i] = head_q[i];
      used_d[i] = used_q[i];
      pw_d[i]   = pw_q[i];
      pr_d[i]   = pr_q[i];
      pcnt_d[i] = pcnt_q[i];
      if (wr_en && wq_q == QW'(i)) begin
        tail_d[i] = tail_q[i] + DAW'(1);
        used_d[i] = used_d[i] + (DAW + 1)'(1);
      end
      if (rd_en && rq_q == QW'(i)) begin
        head_d[i] = head_q[i] + DAW'(1);
        used_d[i] = used_d[i] - (DAW + 1)'(1);
      end
      if (commit && wq_q == QW'(i)) begin
        pw_d[i]   = pw_q[i] + PAW'(1);
        pcnt_d[i] = pcnt_d[i] + (PAW + 1)'(1);
      end
      if (pop && ptr_q == QW'(i)) begin
        pr_d[i]   = pr_q[i] + PAW'(1);
        pcnt_d[i] = pcnt_d[i] - (PAW + 1)'(1);
      end
    end
  end

  always_comb begin
    rd_busy_d = rd_busy;
    if (pop) begin
      rd_busy_d = 1'b1;
    end else if (rd_en && rem_q == 12'd1) begin
      rd_busy_d = 1'b0;
    end
  end

  // Head select looks at next-state counts so the pointer outputs follow a commit/pop by one cycle.
  always_comb begin
    sel_v = 1'b0;
    sel   = '0;
    for (int i = 0; i < NQ; i++) begin
      if (pcnt_d[i] != '0) begin
        sel_v = 1'b1;
        sel   = QW'(i);
      end
    end
    sel_len = pmem[sel][pr_d[sel]];
    // Entry being committed this cycle is not in pmem yet.
    if (commit && wq_q == sel && pw_q[sel] == pr_d[sel]) begin
      sel_len = wcnt_q;
    end
  end

  always_comb begin
    bp_d = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      if (used_q[i] > BpThresh || pcnt_q[i] == PFull) begin
        bp_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      dmem[wq_q][tail_q[wq_q]] <= data;
    end
    if (commit) begin
      pmem[wq_q][pw_q[wq_q]] <= wcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= StIdle;
      wq_q     <= '0;
      len_hi_q <= '0;
      pay_q    <= '0;
      wcnt_q   <= '0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (sof && ((data[3:0] & port_id) != 4'd0)) begin
            st_q     <= StHdr1;
            wq_q     <= prio;
            len_hi_q <= data[7:4];
          end
        end
        StHdr1: begin
          wcnt_q <= '0;
          pay_q  <= hdr_pay;
          st_q   <= hdr_drop ? StDrop : StData;
        end
        StData: begin
          if (!dv) begin
            st_q <= StCommit;
          end else if (wr_en) begin
            wcnt_q <= wcnt_q + 12'd1;
          end
        end
        StCommit: st_q <= StIdle;
        StDrop: begin
          if (!dv) begin
            st_q <= StIdle;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NQ; i++) begin
        tail_q[i] <= '0;
        head_q[i] <= '0;
        used_q[i] <= '0;
        pw_q[i]   <= '0;
        pr_q[i]   <= '0;
        pcnt_q[i] <= '0;
      end
      rd_busy   <= 1'b0;
      rq_q      <= '0;
      rem_q     <= '0;
      ptr_valid <= 1'b0;
      ptr_q     <= '0;
      ptr_len   <= '0;
      bp        <= 1'b0;
      data_dout <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        tail_q[i] <= tail_d[i];
        head_q[i] <= head_d[i];
        used_q[i] <= used_d[i];
        pw_q[i]   <= pw_d[i];
        pr_q[i]   <= pr_d[i];
        pcnt_q[i] <= pcnt_d[i];
      end
      rd_busy <= rd_busy_d;
      if (pop) begin
        rq_q  <= ptr_q;
        rem_q <= ptr_len;
      end else if (rd_en) begin
        rem_q <= rem_q - 12'd1;
      end
      if (rd_en) begin
        data_dout <= dmem[rq_q][head_q[rq_q]];
      end
      ptr_valid <= sel_v && !rd_busy_d;
      ptr_q     <= sel;
      ptr_len   <= sel_v ? sel_len : 12'd0;
      bp        <= bp_d;
    end
  end

`ifdef QM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frm  <= '0;
      stat_drop <= '0;
    end else begin
      if (commit && stat_frm != '1) begin
        stat_frm <= stat_frm + 32'd1;
      end
      if (st_q == StHdr1 && hdr_drop && stat_drop != '1) begin
        stat_drop <= stat_drop + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qm_mq.sv
// Directed self-checking bench for qm_mq: filtering, priority order, truncation, drop/bp, reset.
module tb_qm_mq;
  logic        clk = 1'b0;
  logic        rst, sof, dv, ptr_rd, data_rd;
  logic [3:0]  port_id;
  logic [0:0]  prio;
  logic [7:0]  data;
  logic        bp, ptr_valid, rd_busy;
  logic [0:0]  ptr_q;
  logic [11:0] ptr_len;
  logic [7:0]  data_dout;
`ifdef QM_STATS_EN
  logic [31:0] stat_frm, stat_drop;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qm_mq dut (
    .clk       (clk),
    .rst       (rst),
    .port_id   (port_id),
    .sof       (sof),
    .dv        (dv),
    .prio      (prio),
    .data      (data),
    .bp        (bp),
    .ptr_valid (ptr_valid),
    .ptr_q     (ptr_q),
    .ptr_len   (ptr_len),
    .ptr_rd    (ptr_rd),
    .data_rd   (data_rd),
    .data_dout (data_dout),
    .rd_busy   (rd_busy)
`ifdef QM_STATS_EN
    ,
    .stat_frm  (stat_frm),
    .stat_drop (stat_drop)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [3:0] pmap, input logic [0:0] pq, input logic [11:0] len,
                            input int npay, input logic [7:0] seed);
    sof  = 1'b1;
    dv   = 1'b1;
    prio = pq;
    data = {len[11:8], pmap};
    tick();
    sof  = 1'b0;
    data = len[7:0];
    tick();
    for (int i = 0; i < npay; i++) begin
      data = seed + 8'(i);
      tick();
    end
    dv   = 1'b0;
    data = 8'h00;
    tick();
    tick();
  endtask

  task automatic pop();
    ptr_rd = 1'b1;
    tick();
    ptr_rd = 1'b0;
  endtask

  task automatic read_bytes(input int n, input logic [7:0] seed, input string tag);
    data_rd = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = seed + 8'(i);
      tick();
      chk(tag, 32'(data_dout), 32'(e));
    end
    data_rd = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bp"}, 32'(bp), 32'd0);
    chk({tag, "_ptr_valid"}, 32'(ptr_valid), 32'd0);
    chk({tag, "_ptr_q"}, 32'(ptr_q), 32'd0);
    chk({tag, "_ptr_len"}, 32'(ptr_len), 32'd0);
    chk({tag, "_data_dout"}, 32'(data_dout), 32'd0);
    chk({tag, "_rd_busy"}, 32'(rd_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; sof = 1'b0; dv = 1'b0; ptr_rd = 1'b0; data_rd = 1'b0;
    port_id = 4'b0010; prio = 1'b0; data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst");

    // 1: basic frame to q0
    send_frame(4'b0010, 1'b0, 12'd66, 64, 8'h10);
    chk("t1_valid", 32'(ptr_valid), 32'd1);
    chk("t1_q", 32'(ptr_q), 32'd0);
    chk("t1_len", 32'(ptr_len), 32'd64);
    pop();
    chk("t1_busy", 32'(rd_busy), 32'd1);
    chk("t1_valid_busy", 32'(ptr_valid), 32'd0);
    read_bytes(64, 8'h10, "t1_byte");
    chk("t1_busy_clr", 32'(rd_busy), 32'd0);
    chk("t1_empty", 32'(ptr_valid), 32'd0);
    data_rd = 1'b1;
    tick();
    data_rd = 1'b0;
    chk("t1_dout_hold", 32'(data_dout), 32'h4F);

    // 2: frame for another port is ignored
    send_frame(4'b0100, 1'b0, 12'd66, 64, 8'h20);
    chk("t2_valid", 32'(ptr_valid), 32'd0);
    chk("t2_bp", 32'(bp), 32'd0);

    // 3: strict priority
    send_frame(4'b0010, 1'b0, 12'd66, 64, 8'h30);
    chk("t3_q0_first", 32'(ptr_q), 32'd0);
    send_frame(4'b0010, 1'b1, 12'd102, 100, 8'h40);
    chk("t3_valid", 32'(ptr_valid), 32'd1);
    chk("t3_q", 32'(ptr_q), 32'd1);
    chk("t3_len", 32'(ptr_len), 32'd100);
    pop();
    read_bytes(100, 8'h40, "t3_q1_byte");
    chk("t3_next_valid", 32'(ptr_valid), 32'd1);
    chk("t3_next_q", 32'(ptr_q), 32'd0);
    chk("t3_next_len", 32'(ptr_len), 32'd64);
    pop();
    read_bytes(64, 8'h30, "t3_q0_byte");

    // 5: truncated frame and over-long frame
    send_frame(4'b0010, 1'b0, 12'd66, 30, 8'h50);
    chk("t5_short_len", 32'(ptr_len), 32'd30);
    pop();
    read_bytes(30, 8'h50, "t5_short_byte");
    send_frame(4'b0010, 1'b0, 12'd10, 20, 8'h60);
    chk("t5_long_len", 32'(ptr_len), 32'd8);
    pop();
    read_bytes(8, 8'h60, "t5_long_byte");
    chk("t5_empty", 32'(ptr_valid), 32'd0);

    // 4: bp threshold and drop on insufficient space
    send_frame(4'b0010, 1'b0, 12'd2580, 2578, 8'h90);
    chk("t4_bp_at_thresh", 32'(bp), 32'd0);
    send_frame(4'b0010, 1'b0, 12'd3, 1, 8'hA0);
    chk("t4_bp_over", 32'(bp), 32'd1);
    send_frame(4'b0010, 1'b0, 12'd1602, 1600, 8'hB0);
    chk("t4_head_len", 32'(ptr_len), 32'd2578);
`ifdef QM_STATS_EN
    chk("t4_stat_drop", stat_drop, 32'd1);
    chk("t4_stat_frm", stat_frm, 32'd7);
`endif
    pop();
    read_bytes(2578, 8'h90, "t4_big_byte");
    chk("t4_small_len", 32'(ptr_len), 32'd1);
    pop();
    read_bytes(1, 8'hA0, "t4_small_byte");
    chk("t4_dropped_absent", 32'(ptr_valid), 32'd0);
    tick();
    chk("t4_bp_clear", 32'(bp), 32'd0);

    // 6: reset during a write and a read
    send_frame(4'b0010, 1'b0, 12'd22, 20, 8'h70);
    pop();
    read_bytes(5, 8'h70, "t6_pre_byte");
    data_rd = 1'b1;
    sof = 1'b1; dv = 1'b1; prio = 1'b1; data = 8'h02;
    tick();
    sof = 1'b0; data = 8'h20;
    tick();
    for (int i = 0; i < 3; i++) begin
      data = 8'hE0 + 8'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("t6_rst");
    data = 8'hEE;
    tick();
    tick();
    dv = 1'b0; data_rd = 1'b0;
    tick();
    tick();
    chk("t6_discard_valid", 32'(ptr_valid), 32'd0);
    chk("t6_discard_busy", 32'(rd_busy), 32'd0);
    chk("t6_dout_idle", 32'(data_dout), 32'd0);
    send_frame(4'b0010, 1'b0, 12'd18, 16, 8'hC0);
    chk("t6_valid", 32'(ptr_valid), 32'd1);
    chk("t6_len", 32'(ptr_len), 32'd16);
    pop();
    read_bytes(16, 8'hC0, "t6_byte");
    chk("t6_empty", 32'(ptr_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
